tvm_mem_burst_engine: RTL and testbench

- Synthesizable successor to the VPI-driven memory interface: real RTL that executes host burst read/write tasks against a word-addressed SRAM-style memory port.
- Independent read and write channels, each with its own FSM and beat counter.
- Read data is buffered in a credit-controlled FIFO, and host-side handshakes are preserved.
- Sits between the accelerator datapath (read/write ports) and on-chip or simulated RAM.

---
 rtl/tvm_mem_burst_engine.sv | 258 +++++++++++++++++++++++++
 tb/tb_tvm_mem_burst_engine.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tvm_mem_burst_engine.sv
// Burst read/write engine between host task handshakes and a word-addressed SRAM port.
// Optional statistics counters are enabled by defining TVM_MEM_BURST_STATS_EN.
module tvm_mem_burst_engine #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int SIZE_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  host_read_req,
    input  logic [ADDR_WIDTH-1:0] host_read_addr,
    input  logic [SIZE_WIDTH-1:0] host_read_size,
    output logic                  host_read_busy,
    output logic                  read_done,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data_out,
    output logic                  read_data_valid,
    input  logic                  host_write_req,
    input  logic [ADDR_WIDTH-1:0] host_write_addr,
    input  logic [SIZE_WIDTH-1:0] host_write_size,
    output logic                  host_write_busy,
    output logic                  write_done,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data_in,
    output logic                  write_data_ready,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data
`ifdef TVM_MEM_BURST_STATS_EN
    ,
    input  logic                  stat_clear,
    output logic [31:0]           stat_rd_beats,
    output logic [31:0]           stat_wr_beats,
    output logic [31:0]           stat_rd_stall
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_FLUSH} wr_state_e;

    rd_state_e              rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [SIZE_WIDTH-1:0]  rd_rem_q, rd_rem_d;
    logic                   rd_done_q, rd_done_d;
    logic [MEM_LATENCY-1:0] rd_pipe_q, rd_pipe_d;

    // NOTE: FIFO storage has no reset; emptiness is defined by the pointers and count alone.
    logic [DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       fifo_wr_ptr_q, fifo_rd_ptr_q;
    logic [CNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic                   fifo_push, fifo_pop, fifo_full;
    logic [OCC_W-1:0]       inflight, occupancy;
    logic                   rd_credit, rd_issue;

    wr_state_e              wr_state_q, wr_state_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [SIZE_WIDTH-1:0]  wr_rem_q, wr_rem_d;
    logic                   wr_done_q, wr_done_d;
    logic                   mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_WIDTH-1:0]  mem_wr_addr_q, mem_wr_addr_d;
    logic [DATA_WIDTH-1:0]  mem_wr_data_q, mem_wr_data_d;

    // Credit counts beats already buffered plus beats still in the memory pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight = inflight + OCC_W'(rd_pipe_q[i]);
        end
        occupancy = OCC_W'(fifo_cnt_q) + inflight;
    end

    assign rd_credit       = occupancy < OCC_W'(FIFO_DEPTH);
    assign rd_issue        = (rd_state_q == R_ISSUE) && rd_credit;
    assign fifo_push       = rd_pipe_q[MEM_LATENCY-1];
    assign read_data_valid = fifo_cnt_q != '0;
    assign fifo_pop        = read_en && read_data_valid;
    assign fifo_full       = fifo_cnt_q == CNT_W'(FIFO_DEPTH);

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        rd_state_d   = rd_state_q;
        rd_addr_d    = rd_addr_q;
        rd_rem_d     = rd_rem_q;
        rd_done_d    = 1'b0;
        rd_pipe_d[0] = rd_issue;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
        case (rd_state_q)
            R_IDLE: begin
                if (host_read_req) begin
                    rd_addr_d = host_read_addr;
                    rd_rem_d  = host_read_size;
                    if (host_read_size == '0) rd_done_d  = 1'b1;
                    else                      rd_state_d = R_ISSUE;
                end
            end
            R_ISSUE: begin
                if (rd_issue) begin
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                    rd_rem_d  = rd_rem_q - SIZE_WIDTH'(1);
                    if (rd_rem_q == SIZE_WIDTH'(1)) rd_state_d = R_DRAIN;
                end
            end
            R_DRAIN: begin
                // Leave as the final pop empties everything, so done lands in the next cycle.
                if (rd_pipe_d == '0 && fifo_cnt_d == '0) begin
                    rd_state_d = R_IDLE;
                    rd_done_d  = 1'b1;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_q    <= R_IDLE;
            rd_addr_q     <= '0;
            rd_rem_q      <= '0;
            rd_done_q     <= 1'b0;
            rd_pipe_q     <= '0;
            fifo_wr_ptr_q <= '0;
            fifo_rd_ptr_q <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_rem_q   <= rd_rem_d;
            rd_done_q  <= rd_done_d;
            rd_pipe_q  <= rd_pipe_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (fifo_push) fifo_wr_ptr_q <= fifo_wr_ptr_q + PTR_W'(1);
            if (fifo_pop)  fifo_rd_ptr_q <= fifo_rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[fifo_wr_ptr_q] <= mem_rd_data;
    end

    assert property (@(posedge clk) disable iff (!rst) !(fifo_push && fifo_full && !fifo_pop));

    assign host_read_busy = rd_state_q != R_IDLE;
    assign read_done      = rd_done_q;
    assign read_data_out  = read_data_valid ? fifo_mem[fifo_rd_ptr_q] : '0;
    assign mem_rd_en      = rd_issue;
    assign mem_rd_addr    = rd_addr_q;

    always_comb begin
        wr_state_d    = wr_state_q;
        wr_addr_d     = wr_addr_q;
        wr_rem_d      = wr_rem_q;
        wr_done_d     = 1'b0;
        mem_wr_en_d   = 1'b0;
        mem_wr_addr_d = mem_wr_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        case (wr_state_q)
            W_IDLE: begin
                if (host_write_req) begin
                    wr_addr_d = host_write_addr;
                    wr_rem_d  = host_write_size;
                    if (host_write_size == '0) wr_done_d  = 1'b1;
                    else                       wr_state_d = W_ACCEPT;
                end
            end
            W_ACCEPT: begin
                if (write_en) begin
                    mem_wr_en_d   = 1'b1;
                    mem_wr_addr_d = wr_addr_q;
                    mem_wr_data_d = write_data_in;
                    wr_addr_d     = wr_addr_q + ADDR_WIDTH'(1);
                    wr_rem_d      = wr_rem_q - SIZE_WIDTH'(1);
                    if (wr_rem_q == SIZE_WIDTH'(1)) wr_state_d = W_FLUSH;
                end
            end
            W_FLUSH: begin
                // The last registered beat is on the memory port during this cycle.
                wr_state_d = W_IDLE;
                wr_done_d  = 1'b1;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state_q    <= W_IDLE;
            wr_addr_q     <= '0;
            wr_rem_q      <= '0;
            wr_done_q     <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
        end else begin
            wr_state_q    <= wr_state_d;
            wr_addr_q     <= wr_addr_d;
            wr_rem_q      <= wr_rem_d;
            wr_done_q     <= wr_done_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
        end
    end

    assign host_write_busy  = wr_state_q != W_IDLE;
    assign write_done       = wr_done_q;
    assign write_data_ready = wr_state_q == W_ACCEPT;
    assign mem_wr_en        = mem_wr_en_q;
    assign mem_wr_addr      = mem_wr_addr_q;
    assign mem_wr_data      = mem_wr_data_q;

`ifdef TVM_MEM_BURST_STATS_EN
    logic [31:0] stat_rd_beats_q, stat_wr_beats_q, stat_rd_stall_q;

    // Counters saturate at all-ones; clear wins over any increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_rd_beats_q <= '0;
            stat_wr_beats_q <= '0;
            stat_rd_stall_q <= '0;
        end else if (stat_clear) begin
            stat_rd_beats_q <= '0;
            stat_wr_beats_q <= '0;
            stat_rd_stall_q <= '0;
        end else begin
            if (mem_rd_en && !(&stat_rd_beats_q)) stat_rd_beats_q <= stat_rd_beats_q + 32'd1;
            if (mem_wr_en && !(&stat_wr_beats_q)) stat_wr_beats_q <= stat_wr_beats_q + 32'd1;
            if ((rd_state_q == R_ISSUE) && !rd_credit && !(&stat_rd_stall_q))
                stat_rd_stall_q <= stat_rd_stall_q + 32'd1;
        end
    end

    assign stat_rd_beats = stat_rd_beats_q;
    assign stat_wr_beats = stat_wr_beats_q;
    assign stat_rd_stall = stat_rd_stall_q;
`endif

endmodule

// File: tb/tb_tvm_mem_burst_engine.sv
// Scoreboard bench for tvm_mem_burst_engine: expected beats are queued at request time
// and compared as the DUT issues memory strobes and delivers FIFO data.
module tb_tvm_mem_burst_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        host_read_req = 1'b0;
    logic [31:0] host_read_addr = '0;
    logic [31:0] host_read_size = '0;
    logic        host_read_busy;
    logic        read_done;
    logic        read_en = 1'b0;
    logic [7:0]  read_data_out;
    logic        read_data_valid;
    logic        host_write_req = 1'b0;
    logic [31:0] host_write_addr = '0;
    logic [31:0] host_write_size = '0;
    logic        host_write_busy;
    logic        write_done;
    logic        write_en = 1'b0;
    logic [7:0]  write_data_in = '0;
    logic        write_data_ready;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic [7:0]  mem_rd_data = '0;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [7:0]  mem_wr_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] exp_rd_addr[$];
    logic [7:0]  exp_rd_data[$];
    logic [31:0] exp_wr_addr[$];
    logic [7:0]  exp_wr_data[$];
    int          issue_cyc[$];

    int n_issue, n_pop, n_wr, rd_done_n, wr_done_n;
    int first_pop_cyc, last_pop_cyc, last_wr_cyc, rd_done_cyc, wr_done_cyc;
    logic rd_busy_at_done;

    always #5 clk = ~clk;

    tvm_mem_burst_engine dut (
        .clk              (clk),
        .rst              (rst),
        .host_read_req    (host_read_req),
        .host_read_addr   (host_read_addr),
        .host_read_size   (host_read_size),
        .host_read_busy   (host_read_busy),
        .read_done        (read_done),
        .read_en          (read_en),
        .read_data_out    (read_data_out),
        .read_data_valid  (read_data_valid),
        .host_write_req   (host_write_req),
        .host_write_addr  (host_write_addr),
        .host_write_size  (host_write_size),
        .host_write_busy  (host_write_busy),
        .write_done       (write_done),
        .write_en         (write_en),
        .write_data_in    (write_data_in),
        .write_data_ready (write_data_ready),
        .mem_rd_en        (mem_rd_en),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_data      (mem_rd_data),
        .mem_wr_en        (mem_wr_en),
        .mem_wr_addr      (mem_wr_addr),
        .mem_wr_data      (mem_wr_data)
    );

    function automatic logic [7:0] mem_word(input logic [31:0] a);
        return a[7:0] ^ {a[3:0], a[11:8]} ^ 8'h5A;
    endfunction

    // One-cycle synchronous-read memory.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_word(mem_rd_addr);
    end

    task automatic clear_stats();
        n_issue = 0; n_pop = 0; n_wr = 0; rd_done_n = 0; wr_done_n = 0;
        first_pop_cyc = -1; last_pop_cyc = -1; last_wr_cyc = -1;
        rd_done_cyc = -1; wr_done_cyc = -1; rd_busy_at_done = 1'b1;
        issue_cyc.delete();
    endtask

    task automatic push_read(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            exp_rd_addr.push_back(a + 32'(i));
            exp_rd_data.push_back(mem_word(a + 32'(i)));
        end
    endtask

    // Advance one cycle: sample at the falling edge, then return just after the rising edge.
    task automatic cycle();
        logic [31:0] ea;
        logic [7:0]  ed;
        @(negedge clk);
        cyc++;
        if (mem_rd_en) begin
            n_issue++;
            issue_cyc.push_back(cyc);
            n_checks++;
            if (exp_rd_addr.size() == 0) begin
                n_fail++;
                $display("FAIL rd_issue: unexpected mem_rd_en at addr %08h, expected none", mem_rd_addr);
            end else begin
                ea = exp_rd_addr.pop_front();
                if (mem_rd_addr !== ea) begin
                    n_fail++;
                    $display("FAIL rd_addr: got %08h, expected %08h", mem_rd_addr, ea);
                end
            end
        end
        if (read_en && read_data_valid) begin
            n_pop++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            n_checks++;
            if (exp_rd_data.size() == 0) begin
                n_fail++;
                $display("FAIL rd_data: unexpected pop %02h, expected none", read_data_out);
            end else begin
                ed = exp_rd_data.pop_front();
                if (read_data_out !== ed) begin
                    n_fail++;
                    $display("FAIL rd_data: got %02h, expected %02h", read_data_out, ed);
                end
            end
        end
        if (mem_wr_en) begin
            n_wr++;
            last_wr_cyc = cyc;
            n_checks++;
            if (exp_wr_addr.size() == 0) begin
                n_fail++;
                $display("FAIL wr_beat: unexpected write %08h=%02h, expected none", mem_wr_addr, mem_wr_data);
            end else begin
                ea = exp_wr_addr.pop_front();
                ed = exp_wr_data.pop_front();
                if (mem_wr_addr !== ea || mem_wr_data !== ed) begin
                    n_fail++;
                    $display("FAIL wr_beat: got %08h=%02h, expected %08h=%02h", mem_wr_addr, mem_wr_data, ea, ed);
                end
            end
        end
        if (read_done) begin
            rd_done_n++;
            rd_done_cyc = cyc;
            rd_busy_at_done = host_read_busy;
        end
        if (write_done) begin
            wr_done_n++;
            wr_done_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        n_checks++;
        if ({host_read_busy, read_done, read_data_valid, host_write_busy, write_done,
             write_data_ready, mem_rd_en, mem_wr_en} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, expected 00000000", {host_read_busy, read_done,
                     read_data_valid, host_write_busy, write_done, write_data_ready, mem_rd_en, mem_wr_en});
        end
        n_checks++;
        if ({read_data_out, mem_rd_addr, mem_wr_addr, mem_wr_data} !== 80'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, expected 0", {read_data_out, mem_rd_addr, mem_wr_addr, mem_wr_data});
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cycle();
    endtask

    task automatic wait_read_done(input string name);
        int guard = 0;
        while (rd_done_n == 0 && guard < 100) begin
            cycle();
            guard++;
        end
        n_checks++;
        if (rd_done_n == 0) begin
            n_fail++;
            $display("FAIL %s_timeout: read_done not seen within %0d cycles", name, guard);
        end
        repeat (3) cycle();
    endtask

    task automatic test_basic_read();
        clear_stats();
        push_read(32'h10, 3);
        read_en = 1'b1;
        host_read_req = 1'b1; host_read_addr = 32'h10; host_read_size = 32'd3;
        cycle();
        host_read_req = 1'b0;
        wait_read_done("basic");
        n_checks++;
        if (n_issue != 3) begin n_fail++; $display("FAIL basic_issues: got %0d, expected 3", n_issue); end
        n_checks++;
        if (((issue_cyc.size() == 3) ? issue_cyc[2] - issue_cyc[0] : -1) != 2) begin
            n_fail++; $display("FAIL basic_consecutive: issue spread not 2 cycles (%0d issues)", issue_cyc.size());
        end
        n_checks++;
        if (((issue_cyc.size() > 0) ? first_pop_cyc - issue_cyc[0] : -1) != 2) begin
            n_fail++; $display("FAIL basic_latency: first pop %0d cycles after issue, expected 2",
                               (issue_cyc.size() > 0) ? first_pop_cyc - issue_cyc[0] : -1);
        end
        n_checks++;
        if (rd_done_n != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d, expected 1", rd_done_n); end
        n_checks++;
        if (rd_done_cyc != last_pop_cyc + 1) begin
            n_fail++; $display("FAIL basic_done_time: got cycle %0d, expected %0d", rd_done_cyc, last_pop_cyc + 1);
        end
        n_checks++;
        if (rd_busy_at_done !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b, expected 0", rd_busy_at_done); end
        n_checks++;
        if (exp_rd_data.size() != 0) begin n_fail++; $display("FAIL basic_leftover: %0d beats, expected 0", exp_rd_data.size()); end
        read_en = 1'b0;
    endtask

    task automatic test_backpressure();
        clear_stats();
        push_read(32'h40, 8);
        read_en = 1'b0;
        host_read_req = 1'b1; host_read_addr = 32'h40; host_read_size = 32'd8;
        cycle();
        host_read_req = 1'b0;
        repeat (20) cycle();
        n_checks++;
        if (n_issue != 4) begin n_fail++; $display("FAIL bp_credit_issues: got %0d, expected 4", n_issue); end
        n_checks++;
        if (read_data_valid !== 1'b1 || host_read_busy !== 1'b1) begin
            n_fail++; $display("FAIL bp_stalled: valid=%b busy=%b, expected 1 1", read_data_valid, host_read_busy);
        end
        read_en = 1'b1;
        wait_read_done("bp");
        n_checks++;
        if (n_issue != 8 || n_pop != 8) begin
            n_fail++; $display("FAIL bp_totals: issues=%0d pops=%0d, expected 8 8", n_issue, n_pop);
        end
        n_checks++;
        if (rd_done_n != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d, expected 1", rd_done_n); end
        read_en = 1'b0;
    endtask

    task automatic test_write_wrap();
        logic [7:0] beats [3];
        int guard;
        beats[0] = 8'hA1; beats[1] = 8'hB2; beats[2] = 8'hC3;
        clear_stats();
        exp_wr_addr.push_back(32'hFFFF_FFFE); exp_wr_data.push_back(8'hA1);
        exp_wr_addr.push_back(32'hFFFF_FFFF); exp_wr_data.push_back(8'hB2);
        exp_wr_addr.push_back(32'h0000_0000); exp_wr_data.push_back(8'hC3);
        host_write_req = 1'b1; host_write_addr = 32'hFFFF_FFFE; host_write_size = 32'd3;
        cycle();
        host_write_req = 1'b0;
        for (int b = 0; b < 3; b++) begin
            guard = 0;
            while (!write_data_ready && guard < 20) begin cycle(); guard++; end
            write_en = 1'b1; write_data_in = beats[b];
            cycle();
        end
        write_data_in = 8'hEE;  // extra beat while not ready must be dropped
        cycle();
        write_en = 1'b0;
        guard = 0;
        while (wr_done_n == 0 && guard < 20) begin cycle(); guard++; end
        repeat (3) cycle();
        n_checks++;
        if (n_wr != 3) begin n_fail++; $display("FAIL wr_count: got %0d, expected 3", n_wr); end
        n_checks++;
        if (wr_done_n != 1) begin n_fail++; $display("FAIL wr_done_count: got %0d, expected 1", wr_done_n); end
        n_checks++;
        if (wr_done_cyc != last_wr_cyc + 1) begin
            n_fail++; $display("FAIL wr_done_time: got cycle %0d, expected %0d", wr_done_cyc, last_wr_cyc + 1);
        end
        n_checks++;
        if (host_write_busy !== 1'b0 || write_data_ready !== 1'b0) begin
            n_fail++; $display("FAIL wr_idle: busy=%b ready=%b, expected 0 0", host_write_busy, write_data_ready);
        end
    endtask

    task automatic test_zero_and_ignore();
        int req_c;
        clear_stats();
        host_read_req = 1'b1; host_read_addr = 32'h77; host_read_size = 32'd0;
        host_write_req = 1'b1; host_write_addr = 32'h99; host_write_size = 32'd0;
        cycle();
        req_c = cyc;
        host_read_req = 1'b0; host_write_req = 1'b0;
        repeat (4) cycle();
        n_checks++;
        if (n_issue != 0 || n_wr != 0) begin
            n_fail++; $display("FAIL zero_no_mem: issues=%0d writes=%0d, expected 0 0", n_issue, n_wr);
        end
        n_checks++;
        if (rd_done_n != 1 || rd_done_cyc != req_c + 1) begin
            n_fail++; $display("FAIL zero_rd_done: count=%0d cycle=%0d, expected 1 at %0d", rd_done_n, rd_done_cyc, req_c + 1);
        end
        n_checks++;
        if (wr_done_n != 1 || wr_done_cyc != req_c + 1) begin
            n_fail++; $display("FAIL zero_wr_done: count=%0d cycle=%0d, expected 1 at %0d", wr_done_n, wr_done_cyc, req_c + 1);
        end

        clear_stats();
        push_read(32'h80, 2);
        read_en = 1'b1;
        host_read_req = 1'b1; host_read_addr = 32'h80; host_read_size = 32'd2;
        cycle();
        n_checks++;
        if (host_read_busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy: got %b, expected 1", host_read_busy); end
        host_read_addr = 32'h200; host_read_size = 32'd5;
        repeat (2) cycle();
        host_read_req = 1'b0;
        wait_read_done("ignore");
        n_checks++;
        if (n_issue != 2 || n_pop != 2 || rd_done_n != 1) begin
            n_fail++; $display("FAIL ignore_totals: issues=%0d pops=%0d done=%0d, expected 2 2 1", n_issue, n_pop, rd_done_n);
        end
        read_en = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        clear_stats();
        push_read(32'h300, 6);
        read_en = 1'b0;
        host_read_req = 1'b1; host_read_addr = 32'h300; host_read_size = 32'd6;
        cycle();
        host_read_req = 1'b0;
        repeat (2) cycle();
        n_checks++;
        if (n_issue != 2) begin n_fail++; $display("FAIL rmid_issues: got %0d, expected 2", n_issue); end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({host_read_busy, read_done, read_data_valid, mem_rd_en, mem_wr_en} !== 5'b0 ||
            {read_data_out, mem_rd_addr} !== 40'd0) begin
            n_fail++; $display("FAIL rmid_outputs: busy=%b done=%b valid=%b rd_en=%b data=%02h addr=%08h, expected all 0",
                               host_read_busy, read_done, read_data_valid, mem_rd_en, read_data_out, mem_rd_addr);
        end
        exp_rd_addr.delete();
        exp_rd_data.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_stats();
        push_read(32'h400, 1);
        read_en = 1'b1;
        host_read_req = 1'b1; host_read_addr = 32'h400; host_read_size = 32'd1;
        cycle();
        host_read_req = 1'b0;
        wait_read_done("rmid");
        n_checks++;
        if (n_issue != 1 || n_pop != 1 || rd_done_n != 1) begin
            n_fail++; $display("FAIL rmid_after: issues=%0d pops=%0d done=%0d, expected 1 1 1", n_issue, n_pop, rd_done_n);
        end
        read_en = 1'b0;
    endtask

    task automatic test_concurrent();
        int sent = 0;
        int guard = 0;
        clear_stats();
        push_read(32'h500, 4);
        for (int i = 0; i < 4; i++) begin
            exp_wr_addr.push_back(32'h600 + 32'(i));
            exp_wr_data.push_back(8'h31 + 8'(i));
        end
        read_en = 1'b1;
        host_read_req = 1'b1; host_read_addr = 32'h500; host_read_size = 32'd4;
        host_write_req = 1'b1; host_write_addr = 32'h600; host_write_size = 32'd4;
        cycle();
        host_read_req = 1'b0; host_write_req = 1'b0;
        while ((rd_done_n == 0 || wr_done_n == 0) && guard < 60) begin
            write_en = write_data_ready && (sent < 4);
            write_data_in = 8'h31 + 8'(sent);
            if (write_en) sent++;
            cycle();
            guard++;
        end
        write_en = 1'b0;
        repeat (4) cycle();
        n_checks++;
        if (rd_done_n != 1 || wr_done_n != 1) begin
            n_fail++; $display("FAIL conc_done: rd=%0d wr=%0d, expected 1 1", rd_done_n, wr_done_n);
        end
        n_checks++;
        if (n_issue != 4 || n_pop != 4 || n_wr != 4) begin
            n_fail++; $display("FAIL conc_beats: issues=%0d pops=%0d writes=%0d, expected 4 4 4", n_issue, n_pop, n_wr);
        end
        n_checks++;
        if (exp_rd_data.size() != 0 || exp_wr_data.size() != 0) begin
            n_fail++; $display("FAIL conc_leftover: rd=%0d wr=%0d, expected 0 0", exp_rd_data.size(), exp_wr_data.size());
        end
        read_en = 1'b0;
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_basic_read();
        test_backpressure();
        test_write_wrap();
        test_zero_and_ignore();
        test_reset_mid_read();
        test_concurrent();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
